// File: rtl/read_test_sequencer_if.sv
// Handshake/status bundle between the okHost endpoints, the read-test
// sequencer and the generator/FIFO/pipe-out datapath.
//   master: trigger/wire side (start, abort, transfer_len) plus datapath
//           status (pipe_out_read, fifo_almost_full, fifo_empty)
//   slave : sequencer side (fifo_rst, gen_reset, gen_enable, counters,
//           busy/done/underrun)
interface read_test_sequencer_if;
    logic        start;
    logic        abort;
    logic [31:0] transfer_len;
    logic        pipe_out_read;
    logic        fifo_almost_full;
    logic        fifo_empty;
    logic        fifo_rst;
    logic        gen_reset;
    logic        gen_enable;
    logic [63:0] clk_counts;
    logic [31:0] words_read;
    logic        busy;
    logic        done;
    logic        underrun;

    modport master (
        output start, abort, transfer_len,
        output pipe_out_read, fifo_almost_full, fifo_empty,
        input  fifo_rst, gen_reset, gen_enable,
        input  clk_counts, words_read, busy, done, underrun
    );

    modport slave (
        input  start, abort, transfer_len,
        input  pipe_out_read, fifo_almost_full, fifo_empty,
        output fifo_rst, gen_reset, gen_enable,
        output clk_counts, words_read, busy, done, underrun
    );
endinterface

// File: rtl/read_test_sequencer.sv
// Sequencer for one measured pipe-out read-throughput run:
// flush -> settle -> generate/count reads -> done, timed in okClk cycles.
//   okClk  : clock, rising edge
//   reset  : synchronous, active-high
//   bus    : read_test_sequencer_if.slave (triggers, FIFO status,
//            generator controls, clk_counts/words_read, busy/done/underrun)
module read_test_sequencer #(
    parameter int FLUSH_CYCLES  = 8,
    parameter int SETTLE_CYCLES = 16
) (
    input logic                  okClk,
    input logic                  reset,
    read_test_sequencer_if.slave bus
);
    localparam int PMAX = (FLUSH_CYCLES > SETTLE_CYCLES) ?
                          FLUSH_CYCLES : SETTLE_CYCLES;
    localparam int CW   = $clog2(PMAX + 1);

    typedef enum logic [2:0] {
        IDLE, FLUSH, SETTLE, RUN, DONE
    } state_t;

    state_t      state_q, state_d;
    logic        busy_q, done_q, flush_q;
    logic [CW-1:0] phase_q;
    logic [31:0] len_q;
    logic [63:0] counts_q;
    logic [31:0] words_q;
    logic        underrun_q;
    logic        gen_enable;

    logic start_ok;
    logic run_cnt;
    logic last_read;

    // abort always beats a coincident start
    assign start_ok = bus.start & ~bus.abort &
                      ((state_q == IDLE) | (state_q == DONE));
    assign run_cnt  = (state_q == RUN) & ~bus.abort;
    assign last_read = bus.pipe_out_read & (len_q != 32'd0) &
                       (words_q == len_q - 32'd1);

    // state register; busy/done/flush are flopped from next state so
    // they come straight off a register
    always_ff @(posedge okClk) begin
        if (reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == FLUSH) | (state_d == SETTLE) |
                       (state_d == RUN);
            done_q  <= (state_d == DONE);
            flush_q <= (state_d == FLUSH);
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start_ok) state_d = FLUSH;
            end
            FLUSH: begin
                if (bus.abort)             state_d = IDLE;
                else if (phase_q == '0)    state_d = SETTLE;
            end
            SETTLE: begin
                if (bus.abort)             state_d = IDLE;
                else if (phase_q == '0)
                    state_d = (len_q == 32'd0) ? DONE : RUN;
            end
            RUN: begin
                if (bus.abort)             state_d = IDLE;
                else if (last_read)        state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // output logic; gen_enable has zero-cycle response to almost-full
    always_comb begin
        gen_enable = 1'b0;
        if (state_q == RUN) gen_enable = ~bus.fifo_almost_full;
    end

    // phase counter, length latch and run counters
    always_ff @(posedge okClk) begin
        if (reset) begin
            phase_q    <= '0;
            len_q      <= 32'd0;
            counts_q   <= 64'd0;
            words_q    <= 32'd0;
            underrun_q <= 1'b0;
        end else begin
            if (start_ok) begin
                len_q      <= bus.transfer_len;
                counts_q   <= 64'd0;
                words_q    <= 32'd0;
                underrun_q <= 1'b0;
                phase_q    <= CW'(FLUSH_CYCLES - 1);
            end else begin
                if (state_q == FLUSH && phase_q == '0)
                    phase_q <= CW'(SETTLE_CYCLES - 1);
                else if (phase_q != '0)
                    phase_q <= phase_q - 1'b1;
                if (run_cnt) begin
                    counts_q <= counts_q + 64'd1;
                    if (bus.pipe_out_read) begin
                        words_q <= words_q + 32'd1;
                        if (bus.fifo_empty) underrun_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.fifo_rst   = flush_q;
    assign bus.gen_reset  = flush_q;
    assign bus.gen_enable = gen_enable;
    assign bus.clk_counts = counts_q;
    assign bus.words_read = words_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.underrun   = underrun_q;
endmodule

// File: tb/tb_read_test_sequencer.sv
// Self-checking bench for read_test_sequencer: table-driven runs with a
// done-triggered scoreboard, plus abort/collision/reset sequences.
module tb_read_test_sequencer;
    localparam int F = 8;
    localparam int S = 16;

    logic okClk;
    logic reset;

    read_test_sequencer_if bus ();

    read_test_sequencer #(
        .FLUSH_CYCLES (F),
        .SETTLE_CYCLES(S)
    ) dut (
        .okClk(okClk),
        .reset(reset),
        .bus  (bus)
    );

    initial okClk = 1'b0;
    always #5 okClk = ~okClk;

    typedef struct {
        int unsigned len;
        int          per;
        int          afs;
        int          afl;
        int          eidx;
        int unsigned exp_words;
        int unsigned exp_counts;
        bit          exp_ur;
        int          exp_en_low;
    } vec_t;

    typedef struct {
        logic [31:0] words;
        logic [63:0] counts;
        logic        ur;
    } exp_t;

    exp_t sbq[$];
    int   applied = 0;
    int   miscompares = 0;
    vec_t vt[6];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge okClk);
        #1;
    endtask

    // scoreboard: one expectation per run that should reach DONE
    logic done_prev = 1'b0;
    exp_t mon_e;
    always @(posedge okClk) begin
        #1;
        if (bus.done === 1'b1 && done_prev !== 1'b1) begin
            if (sbq.size() == 0) begin
                chk("sb_unexpected_done", 64'd1, 64'd0);
            end else begin
                mon_e = sbq.pop_front();
                chk("sb_words_read", bus.words_read, mon_e.words);
                chk("sb_clk_counts", bus.clk_counts, mon_e.counts);
                chk("sb_underrun", bus.underrun, mon_e.ur);
            end
        end
        done_prev = bus.done;
    end

    task automatic run_vec(input vec_t v);
        int   nf = 0, ng = 0, ns = 0, k = 0, r = 0;
        int   en_low = 0, en_bad = 0, en_hi = 0, guard = 0;
        int   ur_k = -1;
        bit   ur_pre = 0, ur_post = 0;
        exp_t e;
        e.words  = v.exp_words;
        e.counts = 64'(v.exp_counts);
        e.ur     = v.exp_ur;
        sbq.push_back(e);
        bus.start = 1'b1;
        bus.transfer_len = v.len;
        tick();
        bus.start = 1'b0;
        bus.transfer_len = $urandom;
        // reads/empty outside RUN must be ignored
        bus.pipe_out_read = 1'b1;
        bus.fifo_empty = 1'b1;
        bus.fifo_almost_full = 1'b0;
        while (bus.fifo_rst && guard < 100) begin
            nf++;
            if (bus.gen_reset) ng++;
            if (bus.gen_enable) en_hi++;
            tick();
            guard++;
        end
        while (bus.busy && !bus.gen_enable && guard < 200) begin
            ns++;
            tick();
            guard++;
        end
        chk("flush_len", nf, F);
        chk("gen_reset_len", ng, F);
        chk("settle_len", ns, S);
        chk("entry_done", bus.done, v.len == 0);
        while (!bus.done && k < 5000) begin
            if (ur_k >= 0 && k == ur_k + 1) ur_post = bus.underrun;
            bus.fifo_almost_full = (k >= v.afs && k < v.afs + v.afl);
            bus.pipe_out_read = (k % v.per == 0);
            bus.fifo_empty = bus.pipe_out_read && (r == v.eidx);
            if (bus.fifo_empty) begin
                ur_k = k;
                ur_pre = bus.underrun;
            end
            #1;
            if (bus.gen_enable !== !bus.fifo_almost_full) en_bad++;
            if (!bus.gen_enable) en_low++;
            if (bus.pipe_out_read) r++;
            tick();
            k++;
        end
        if (k >= 5000) chk("run_timeout", 64'd1, 64'd0);
        bus.pipe_out_read = 1'b0;
        bus.fifo_empty = 1'b0;
        bus.fifo_almost_full = 1'b0;
        chk("run_cycles", k, v.exp_counts);
        chk("en_low_cycles", en_low, v.exp_en_low);
        chk("en_follow_af", en_bad, 0);
        chk("en_in_flush", en_hi, 0);
        #1;
        chk("en_after_done", bus.gen_enable, 1'b0);
        if (v.exp_ur) begin
            chk("ur_before", ur_pre, 1'b0);
            chk("ur_after", ur_post, 1'b1);
        end
        bus.pipe_out_read = 1'b1;
        bus.fifo_empty = 1'b1;
        tick();
        tick();
        chk("done_hold_words", bus.words_read, v.exp_words);
        chk("done_hold_ur", bus.underrun, v.exp_ur);
        chk("done_stays", bus.done, 1'b1);
        bus.pipe_out_read = 1'b0;
        bus.fifo_empty = 1'b0;
    endtask

    task automatic go_to_run(input int unsigned len);
        int g = 0;
        bus.start = 1'b1;
        bus.transfer_len = len;
        tick();
        bus.start = 1'b0;
        while (!bus.gen_enable && g < 100) begin
            tick();
            g++;
        end
        chk("reach_run", bus.gen_enable, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int k;
        exp_t e;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.transfer_len = 32'd0;
        bus.pipe_out_read = 1'b0;
        bus.fifo_almost_full = 1'b0;
        bus.fifo_empty = 1'b0;
        tick();
        tick();
        chk("rst_flags", {bus.fifo_rst, bus.gen_reset, bus.gen_enable,
                          bus.busy, bus.done, bus.underrun}, 64'd0);
        chk("rst_counts", bus.clk_counts, 64'd0);
        chk("rst_words", bus.words_read, 64'd0);
        reset = 1'b0;
        tick();

        //        len  per afs afl eidx words counts ur enlow
        vt[0] = '{1024, 1,  0,  0, -1, 1024, 1024, 0, 0};
        vt[1] = '{200,  1, 20, 50, -1,  200,  200, 0, 50};
        vt[2] = '{0,    1,  0,  0, -1,    0,    0, 0, 0};
        vt[3] = '{10,   3,  5,  4,  4,   10,   28, 1, 4};
        vt[4] = '{5,    1,  0,  0, -1,    5,    5, 0, 0};
        vt[5] = '{1,    2,  0,  0, -1,    1,    1, 0, 0};
        for (int i = 0; i < 6; i++) run_vec(vt[i]);

        // abort while DONE is ignored
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_in_done", bus.done, 1'b1);

        // abort after 100 RUN cycles with 40 reads
        go_to_run(1000);
        for (int j = 0; j < 100; j++) begin
            bus.pipe_out_read = (j < 40);
            tick();
        end
        bus.pipe_out_read = 1'b0;
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_words", bus.words_read, 64'd40);
        chk("abort_counts", bus.clk_counts, 64'd100);
        chk("abort_idle", {bus.busy, bus.done}, 64'd0);

        // start+abort together in RUN -> IDLE, start dropped
        go_to_run(1000);
        tick();
        tick();
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("collide_busy", bus.busy, 1'b0);
        tick();
        chk("collide_no_flush", {bus.busy, bus.fifo_rst}, 64'd0);

        // start during SETTLE is ignored, length not relatched
        e.words = 32'd3;
        e.counts = 64'd3;
        e.ur = 1'b0;
        sbq.push_back(e);
        bus.start = 1'b1;
        bus.transfer_len = 32'd3;
        tick();
        t = 0;
        while (!bus.gen_enable && t < 200) begin
            bus.start = (t == F);
            bus.transfer_len = (t == F) ? 32'd77 : 32'd0;
            tick();
            t++;
        end
        bus.start = 1'b0;
        chk("settle_start_ignored", t, F + S);
        k = 0;
        bus.pipe_out_read = 1'b1;
        while (!bus.done && k < 200) begin
            tick();
            k++;
        end
        bus.pipe_out_read = 1'b0;
        chk("settle_run_cycles", k, 3);

        // reset mid-run, coincident with start
        go_to_run(100);
        bus.pipe_out_read = 1'b1;
        bus.fifo_empty = 1'b1;
        tick();
        tick();
        tick();
        bus.pipe_out_read = 1'b0;
        bus.fifo_empty = 1'b0;
        chk("pre_rst_underrun", bus.underrun, 1'b1);
        reset = 1'b1;
        bus.start = 1'b1;
        tick();
        reset = 1'b0;
        bus.start = 1'b0;
        chk("midrst_flags", {bus.fifo_rst, bus.gen_reset, bus.gen_enable,
                             bus.busy, bus.done, bus.underrun}, 64'd0);
        chk("midrst_counts", bus.clk_counts, 64'd0);
        chk("midrst_words", bus.words_read, 64'd0);
        tick();
        chk("midrst_start_dropped", bus.busy, 1'b0);

        tick();
        tick();
        chk("sb_drained", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 applied, miscompares);
        $finish;
    end
endmodule
